// File: rtl/eth_rx_frame_fifo.sv
// eth_rx_frame_fifo: store-and-forward receive frame buffer with MAC filtering, drop-on-error and backpressured replay.
module eth_rx_frame_fifo #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  input_axis_tdata,
  input  logic        input_axis_tvalid,
  input  logic        input_axis_tlast,
  input  logic        input_axis_tuser,
  output logic [7:0]  output_axis_tdata,
  output logic        output_axis_tvalid,
  input  logic        output_axis_tready,
  output logic        output_axis_tlast,
  input  logic [47:0] mac_addr,
  input  logic        promiscuous,
  input  logic        accept_multicast,
  output logic        frame_good,
  output logic        drop_bad,
  output logic        drop_filter,
  output logic        drop_overflow
);
  localparam int AW = ADDR_WIDTH;
  localparam logic [AW:0] ONE = 1;
  typedef enum logic [1:0] {C_NONE, C_BAD, C_FILT, C_OVF} cause_t;
  logic [8:0] mem [2**AW];
  logic [AW:0] wr_ptr_cur, wr_ptr_commit, rd_ptr;
  logic [2:0] byte_cnt;
  cause_t cause, cause_n;
  logic uc_match, bc_match, mc_bit, uc_now, bc_now, mc_now, filt_fail;
  logic full, empty, wr_en, rd_en, store_out, mem_valid, out_valid;
  logic [8:0] mem_q;
  logic [7:0] mac_byte;
  always_comb begin
    full = (wr_ptr_cur - rd_ptr) == {1'b1, {AW{1'b0}}};
    empty = rd_ptr == wr_ptr_commit;
    mac_byte = 8'(mac_addr >> (6'd40 - {byte_cnt, 3'b000}));
    uc_now = uc_match & (input_axis_tdata == mac_byte);
    bc_now = bc_match & (input_axis_tdata == 8'hff);
    mc_now = byte_cnt == 3'd0 ? input_axis_tdata[0] : mc_bit;
    filt_fail = byte_cnt == 3'd5 && !(promiscuous | bc_now | (mc_now & accept_multicast) | uc_now);
    // an earlier cause wins; a full buffer outranks a filter miss on the same byte
    cause_n = cause != C_NONE ? cause : full ? C_OVF : filt_fail ? C_FILT : C_NONE;
    wr_en = input_axis_tvalid && !full && cause == C_NONE;
    store_out = !out_valid || output_axis_tready;
    rd_en = !empty && (!mem_valid || store_out);
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_cur[AW-1:0]] <= {input_axis_tlast, input_axis_tdata};
    if (rd_en) mem_q <= mem[rd_ptr[AW-1:0]];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_cur <= '0;
      wr_ptr_commit <= '0;
      byte_cnt <= '0;
      cause <= C_NONE;
      uc_match <= 1'b1;
      bc_match <= 1'b1;
      mc_bit <= 1'b0;
      frame_good <= 1'b0;
      drop_bad <= 1'b0;
      drop_filter <= 1'b0;
      drop_overflow <= 1'b0;
    end else begin
      frame_good <= 1'b0;
      drop_bad <= 1'b0;
      drop_filter <= 1'b0;
      drop_overflow <= 1'b0;
      if (input_axis_tvalid) begin
        if (wr_en) wr_ptr_cur <= wr_ptr_cur + ONE;
        if (byte_cnt != 3'd6) begin
          byte_cnt <= byte_cnt + 3'd1;
          uc_match <= uc_now;
          bc_match <= bc_now;
          mc_bit <= mc_now;
        end
        cause <= cause_n;
        if (input_axis_tlast) begin
          byte_cnt <= '0;
          cause <= C_NONE;
          uc_match <= 1'b1;
          bc_match <= 1'b1;
          if (cause_n != C_NONE || input_axis_tuser || byte_cnt < 3'd5) begin
            wr_ptr_cur <= wr_ptr_commit;
            drop_overflow <= cause_n == C_OVF;
            drop_filter <= cause_n == C_FILT;
            drop_bad <= cause_n == C_NONE || cause_n == C_BAD;
          end else begin
            wr_ptr_commit <= wr_ptr_cur + ONE;
            frame_good <= 1'b1;
          end
        end
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      mem_valid <= 1'b0;
      out_valid <= 1'b0;
      output_axis_tdata <= '0;
      output_axis_tlast <= 1'b0;
    end else begin
      if (rd_en) begin
        rd_ptr <= rd_ptr + ONE;
        mem_valid <= 1'b1;
      end else if (store_out) mem_valid <= 1'b0;
      if (store_out) begin
        out_valid <= mem_valid;
        output_axis_tdata <= mem_q[7:0];
        output_axis_tlast <= mem_q[8];
      end
    end
  end
  assign output_axis_tvalid = out_valid;
endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// tb_eth_rx_frame_fifo: directed scoreboard bench; a 2048-byte and a 64-byte instance share the input bus.
module tb_eth_rx_frame_fifo;
  localparam logic [47:0] MAC = 48'h02_00_00_00_00_01;
  logic clk = 0, rst = 1;
  logic [7:0] tdata = 0;
  logic tlast = 0, tuser = 0, va = 0, vb = 0;
  logic [47:0] mac_addr = MAC;
  logic promisc = 0, acc_mc = 0, rdy_a = 1, b_rdy = 1, rand_en = 0, rnd = 0;
  logic a_rdy;
  logic [7:0] a_data, b_data;
  logic a_valid, a_last, a_fg, a_bad, a_filt, a_ovf;
  logic b_valid, b_last, b_fg, b_bad, b_filt, b_ovf;
  logic [8:0] exp_a[$], exp_b[$], got_a[$], got_b[$];
  int ga_idx = 0, gb_idx = 0;
  int fg_a = 0, bad_a = 0, filt_a = 0, ovf_a = 0, fg_b = 0, bad_b = 0, ovf_b = 0;
  int stall_err = 0, vectors = 0, miscompares = 0;
  logic a_hold = 0;
  logic [8:0] a_held = 0;
  assign a_rdy = rand_en ? rnd : rdy_a;
  always #5 clk = ~clk;
  eth_rx_frame_fifo #(.ADDR_WIDTH(11)) dut_a (
    .clk(clk), .rst(rst), .input_axis_tdata(tdata), .input_axis_tvalid(va),
    .input_axis_tlast(tlast), .input_axis_tuser(tuser), .output_axis_tdata(a_data),
    .output_axis_tvalid(a_valid), .output_axis_tready(a_rdy), .output_axis_tlast(a_last),
    .mac_addr(mac_addr), .promiscuous(promisc), .accept_multicast(acc_mc),
    .frame_good(a_fg), .drop_bad(a_bad), .drop_filter(a_filt), .drop_overflow(a_ovf));
  eth_rx_frame_fifo #(.ADDR_WIDTH(6)) dut_b (
    .clk(clk), .rst(rst), .input_axis_tdata(tdata), .input_axis_tvalid(vb),
    .input_axis_tlast(tlast), .input_axis_tuser(tuser), .output_axis_tdata(b_data),
    .output_axis_tvalid(b_valid), .output_axis_tready(b_rdy), .output_axis_tlast(b_last),
    .mac_addr(mac_addr), .promiscuous(promisc), .accept_multicast(acc_mc),
    .frame_good(b_fg), .drop_bad(b_bad), .drop_filter(b_filt), .drop_overflow(b_ovf));
  initial forever begin
    @(posedge clk);
    #1 rnd = 1'($urandom_range(0, 1));
  end
  always @(negedge clk) begin
    if (a_valid && a_rdy) got_a.push_back({a_last, a_data});
    if (b_valid && b_rdy) got_b.push_back({b_last, b_data});
    if (!rst && a_hold && (a_valid !== 1'b1 || {a_last, a_data} !== a_held)) stall_err <= stall_err + 1;
    a_hold <= a_valid && !a_rdy;
    a_held <= {a_last, a_data};
    fg_a <= fg_a + int'(a_fg);
    bad_a <= bad_a + int'(a_bad);
    filt_a <= filt_a + int'(a_filt);
    ovf_a <= ovf_a + int'(a_ovf);
    fg_b <= fg_b + int'(b_fg);
    bad_b <= bad_b + int'(b_bad | b_filt);
    ovf_b <= ovf_b + int'(b_ovf);
  end
  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic send(input bit inst, input logic [47:0] dst, input int len, input bit bad, input bit keep);
    for (int i = 0; i < len; i++) begin
      logic [7:0] d;
      d = i < 6 ? dst[47-8*i -: 8] : 8'($urandom);
      @(posedge clk);
      #1;
      tdata = d;
      tlast = i == len - 1;
      tuser = bad && i == len - 1;
      va = !inst;
      vb = inst;
      if (keep && inst) exp_b.push_back({tlast, d});
      if (keep && !inst) exp_a.push_back({tlast, d});
    end
    @(posedge clk);
    #1;
    va = 0; vb = 0; tlast = 0; tuser = 0;
  endtask
  task automatic drain(input bit inst, input string tag);
    int t = 0, ng;
    while (t < 20000 && (inst ? got_b.size() - gb_idx < exp_b.size() : got_a.size() - ga_idx < exp_a.size())) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    #1;
    if (inst) begin
      ng = got_b.size() - gb_idx;
      chk({tag, " count"}, ng, exp_b.size());
      foreach (exp_b[i]) if (i < ng) chk(tag, got_b[gb_idx+i], exp_b[i]);
      gb_idx += ng;
      exp_b.delete();
    end else begin
      ng = got_a.size() - ga_idx;
      chk({tag, " count"}, ng, exp_a.size());
      foreach (exp_a[i]) if (i < ng) chk(tag, got_a[ga_idx+i], exp_a[i]);
      ga_idx += ng;
      exp_a.delete();
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset tvalid", a_valid, 0);
    chk("reset tdata", a_data, 0);
    chk("reset tlast", a_last, 0);
    chk("reset pulses", {a_fg, a_bad, a_filt, a_ovf}, 0);
    rst = 0;
    send(0, MAC, 64, 0, 1);
    @(negedge clk);
    chk("latency N", a_valid, 0);
    @(negedge clk);
    chk("latency N+1", a_valid, 0);
    @(negedge clk);
    chk("latency N+2", a_valid, 1);
    drain(0, "unicast");
    chk("unicast good", fg_a, 1);
    send(0, MAC, 64, 1, 0);
    send(0, MAC, 60, 0, 1);
    drain(0, "bad then good");
    chk("bad pulse", bad_a, 1);
    chk("good after bad", fg_a, 2);
    send(0, 48'h02_00_00_00_00_02, 64, 0, 0);
    promisc = 1;
    send(0, 48'h02_00_00_00_00_02, 64, 0, 1);
    promisc = 0;
    send(0, 48'hff_ff_ff_ff_ff_ff, 64, 0, 1);
    send(0, 48'h01_00_5e_00_00_01, 64, 0, 0);
    acc_mc = 1;
    send(0, 48'h01_00_5e_00_00_01, 64, 0, 1);
    acc_mc = 0;
    drain(0, "filter");
    chk("filter drops", filt_a, 2);
    chk("filter passes", fg_a, 5);
    b_rdy = 0;
    send(1, MAC, 40, 0, 1);
    send(1, MAC, 40, 0, 0);
    send(1, MAC, 3, 0, 0);
    repeat (5) @(negedge clk);
    chk("ovf commit", fg_b, 1);
    chk("ovf drop", ovf_b, 1);
    chk("ovf runt", bad_b, 1);
    chk("stalled valid", b_valid, 1);
    b_rdy = 1;
    drain(1, "overflow out");
    send(1, MAC, 64, 0, 1);
    drain(1, "full-size frame");
    chk("full-size commit", fg_b, 2);
    send(1, MAC, 65, 0, 0);
    drain(1, "oversize frame");
    chk("oversize drop", ovf_b, 2);
    rand_en = 1;
    for (int f = 0; f < 10; f++) send(0, MAC, 100, 0, 1);
    drain(0, "backpressure");
    rand_en = 0;
    chk("stall stability", stall_err, 0);
    chk("backpressure good", fg_a, 15);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      tdata = i < 6 ? MAC[47-8*i -: 8] : 8'(i);
      va = 1;
    end
    @(posedge clk);
    #1;
    rst = 1;
    va = 0;
    @(negedge clk);
    chk("mid reset tvalid", a_valid, 0);
    chk("mid reset tdata", a_data, 0);
    chk("mid reset tlast", a_last, 0);
    @(posedge clk);
    #1;
    rst = 0;
    send(0, MAC, 64, 0, 1);
    drain(0, "after reset");
    chk("after reset good", fg_a, 16);
    chk("no ovf on big", ovf_a, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
